// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// Holds the FSM state encoding and the bit-counter width function.
// The PARITY state only exists when BIT_SERIALIZER_PARITY_EN is defined.
package bit_ser_pkg;

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

    // Counter wide enough to hold 0..width
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bus of the bit serializer.
// Carries no logic, so it adds no latency.
// Backpressure is din_ready, driven by the slave (the serializer).
interface bit_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;

    // Producer / observer side
    modport master (
        output din, din_valid,
        input  din_ready, ser_out, ser_valid, busy
    );

    // Serializer side
    modport slave (
        input  din, din_valid,
        output din_ready, ser_out, ser_valid, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words out one bit per clk on ser_out (optional even parity via BIT_SERIALIZER_PARITY_EN).
// Latency: word accepted at edge k puts its first bit on ser_out in the cycle after edge k; no gaps between chained words.
// Backpressure: din_ready is high only in IDLE and in the final bit slot of a frame; din_valid is ignored otherwise.
module bit_serializer
    import bit_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    bit_serializer_if.slave  bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;        // index of the data bit currently on ser_out
    logic [WIDTH-1:0] shreg;      // remaining bits, next one at the outgoing end
    logic             ser_out_q;
    logic             ser_valid_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par_q;      // even parity of the word in flight
`endif

    logic             in_rdy;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_sh;
    logic [WIDTH-1:0] next_sh;

    // Ready in IDLE or in the last slot of the frame, so chained words need no bubble
    always_comb begin
`ifdef BIT_SERIALIZER_PARITY_EN
        in_rdy = (state == IDLE) || (state == PARITY);
`else
        in_rdy = (state == IDLE) || ((state == SHIFT) && (cnt == LAST));
`endif
        accept    = bus.din_valid && in_rdy;
        first_bit = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
        load_sh   = MSB_FIRST ? (bus.din << 1) : (bus.din >> 1);
        next_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        next_sh   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end

    // FSM, shift register, counter and registered serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            ser_out_q   <= IDLE_LVL;
            ser_valid_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else if (accept) begin
            // Load a new word; its first bit goes straight to the output register
            state       <= SHIFT;
            cnt         <= '0;
            shreg       <= load_sh;
            ser_out_q   <= first_bit;
            ser_valid_q <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q       <= ^bus.din;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt != LAST) begin
                        cnt       <= cnt + 1'b1;
                        shreg     <= next_sh;
                        ser_out_q <= next_bit;
                    end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state     <= PARITY;
                        ser_out_q <= par_q;
`else
                        state       <= IDLE;
                        ser_out_q   <= IDLE_LVL;
                        ser_valid_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    ser_out_q   <= IDLE_LVL;
                    ser_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready = in_rdy;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.busy      = (state != IDLE);

endmodule
